// File: rtl/vga_color_reporter.sv
// Samples one pixel per VGA frame, classifies its colour as an ASCII code and
// hands it to the UART transmitter whenever the reported colour changes.
module vga_color_reporter #(
   parameter int SAMPLE_COL = 320,
   parameter int SAMPLE_ROW = 240
) (
   input  logic       CLK,
   input  logic       i_Reset,
   input  logic       i_HSync,
   input  logic       i_VSync,
   input  logic [2:0] i_Red,
   input  logic [2:0] i_Green,
   input  logic [2:0] i_Blue,
   input  logic       i_TX_Active,
   input  logic       i_TX_Done,
   output logic       o_TX_DV,
   output logic [7:0] o_TX_Byte,
   output logic       o_Sample_Valid
);

   typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

   localparam logic [9:0] C_COL = 10'(SAMPLE_COL);
   localparam logic [9:0] C_ROW = 10'(SAMPLE_ROW);

   function automatic logic [7:0] classify(input logic [8:0] rgb);
      logic [7:0] code;
      case (rgb)
         9'o700:  code = 8'h31;
         9'o070:  code = 8'h32;
         9'o007:  code = 8'h33;
         9'o000:  code = 8'h30;
         default: code = 8'h3F;
      endcase
      return code;
   endfunction

   logic       r_HSync_d, r_VSync_d;
   logic [9:0] r_Col, r_Row;
   logic [8:0] r_Cap_RGB;
   logic       r_Frame_Hit, r_Sample_Valid;
   logic       r_Pending, r_None_Sent;
   logic [7:0] r_Pending_Code, r_Last_Sent, r_TX_Byte;
   state_t     r_State, w_Next;

   logic [9:0] w_Col;
   logic       w_Capture, w_EOF, w_Load, w_Send, w_TX_DV;
   logic [7:0] w_Code;

   // w_Col is the column index of the pixel present in the current cycle
   always_comb begin
      w_Col = r_Col;
      if (!r_HSync_d)
         w_Col = 10'd0;
      else if (r_Col != 10'h3FF)
         w_Col = r_Col + 10'd1;
   end

   assign w_Capture = i_HSync & i_VSync & (w_Col == C_COL) & (r_Row == C_ROW);
   assign w_EOF     = ~i_VSync & r_VSync_d;
   assign w_Code    = classify(r_Cap_RGB);
   assign w_Load    = w_EOF & r_Frame_Hit & ((w_Code != r_Last_Sent) | r_None_Sent);
   assign w_Send    = (r_State == SEND) & ~i_TX_Active;

   always_ff @(posedge CLK or posedge i_Reset) begin
      if (i_Reset) begin
         r_HSync_d      <= 1'b0;
         r_VSync_d      <= 1'b0;
         r_Col          <= 10'd0;
         r_Row          <= 10'd0;
         r_Cap_RGB      <= 9'd0;
         r_Frame_Hit    <= 1'b0;
         r_Sample_Valid <= 1'b0;
      end else begin
         r_HSync_d <= i_HSync;
         r_VSync_d <= i_VSync;
         if (i_HSync)
            r_Col <= w_Col;
         if (!i_VSync)
            r_Row <= 10'd0;
         else if (!i_HSync && r_HSync_d && r_Row != 10'h3FF)
            r_Row <= r_Row + 10'd1;
         if (w_Capture) begin
            r_Cap_RGB      <= {i_Red, i_Green, i_Blue};
            r_Frame_Hit    <= 1'b1;
            r_Sample_Valid <= 1'b1;
         end else if (w_EOF) begin
            r_Frame_Hit <= 1'b0;
         end
      end
   end

   // A fresh end-of-frame load wins over the clear caused by a send
   always_ff @(posedge CLK or posedge i_Reset) begin
      if (i_Reset) begin
         r_Pending      <= 1'b0;
         r_Pending_Code <= 8'h00;
         r_Last_Sent    <= 8'h00;
         r_None_Sent    <= 1'b1;
         r_TX_Byte      <= 8'h00;
         r_State        <= IDLE;
      end else begin
         r_State <= w_Next;
         if (w_Load) begin
            r_Pending      <= 1'b1;
            r_Pending_Code <= w_Code;
         end else if (w_Send) begin
            r_Pending <= 1'b0;
         end
         if (w_Send) begin
            r_Last_Sent <= r_TX_Byte;
            r_None_Sent <= 1'b0;
         end
         if (r_State == IDLE && w_Next == SEND)
            r_TX_Byte <= r_Pending_Code;
      end
   end

   // SEND falls back to IDLE if the UART went busy, so DV never overlaps Active
   always_comb begin
      w_Next  = r_State;
      w_TX_DV = 1'b0;
      case (r_State)
         IDLE: if (r_Pending && !i_TX_Active) w_Next = SEND;
         SEND: begin
            if (i_TX_Active) begin
               w_Next = IDLE;
            end else begin
               w_TX_DV = 1'b1;
               w_Next  = WAIT;
            end
         end
         WAIT: if (i_TX_Done) w_Next = IDLE;
         default: w_Next = IDLE;
      endcase
   end

   assign o_TX_DV        = w_TX_DV;
   assign o_TX_Byte      = r_TX_Byte;
   assign o_Sample_Valid = r_Sample_Valid;

endmodule

// File: tb/tb_vga_color_reporter.sv
// Directed bench for vga_color_reporter: scoreboarded report bytes, latency,
// change-only reporting, TX back-pressure and asynchronous reset.
module tb_vga_color_reporter;

   localparam int SC   = 5;
   localparam int SR   = 3;
   localparam int NCOL = 8;
   localparam int NROW = 6;

   logic       CLK = 1'b0;
   logic       i_Reset = 1'b0;
   logic       i_HSync = 1'b0, i_VSync = 1'b0;
   logic [2:0] i_Red = 3'd0, i_Green = 3'd0, i_Blue = 3'd0;
   logic       i_TX_Active = 1'b0, i_TX_Done = 1'b0;
   logic       o_TX_DV;
   logic [7:0] o_TX_Byte;
   logic       o_Sample_Valid;

   int         n_vec = 0, n_err = 0, cyc = 0, lat_chk = -1, dv_count = 0;
   logic       prev_dv = 1'b0;
   logic [7:0] exp_q[$];
   logic [7:0] e;

   vga_color_reporter #(.SAMPLE_COL(SC), .SAMPLE_ROW(SR)) dut (
      .CLK(CLK), .i_Reset(i_Reset), .i_HSync(i_HSync), .i_VSync(i_VSync),
      .i_Red(i_Red), .i_Green(i_Green), .i_Blue(i_Blue),
      .i_TX_Active(i_TX_Active), .i_TX_Done(i_TX_Done),
      .o_TX_DV(o_TX_DV), .o_TX_Byte(o_TX_Byte), .o_Sample_Valid(o_Sample_Valid)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc++;

   // Scoreboard: every DV must match the oldest expected byte
   always @(negedge CLK) begin
      if (!i_Reset) begin
         if (o_TX_DV) begin
            dv_count++;
            n_vec++;
            assert (i_TX_Active === 1'b0) else begin
               n_err++; $error("FAIL dv_while_active observed=%b expected=0", i_TX_Active);
            end
            n_vec++;
            assert (prev_dv === 1'b0) else begin
               n_err++; $error("FAIL dv_back_to_back observed=%b expected=0", prev_dv);
            end
            n_vec++;
            if (exp_q.size() == 0) begin
               n_err++; $error("FAIL unexpected_dv observed=%h expected=none", o_TX_Byte);
            end else begin
               e = exp_q.pop_front();
               assert (o_TX_Byte === e) else begin
                  n_err++; $error("FAIL tx_byte observed=%h expected=%h", o_TX_Byte, e);
               end
            end
            if (lat_chk >= 0) begin
               n_vec++;
               assert (cyc === lat_chk + 2) else begin
                  n_err++; $error("FAIL dv_latency observed=%0d expected=%0d", cyc - lat_chk, 2);
               end
               lat_chk = -1;
            end
         end
         prev_dv = o_TX_DV;
      end else begin
         prev_dv = 1'b0;
      end
   end

   // UART model: acknowledge each byte 10 cycles after its request
   initial begin
      forever begin
         @(negedge CLK);
         if (o_TX_DV) begin
            repeat (10) @(posedge CLK);
            #1 i_TX_Done = 1'b1;
            @(posedge CLK);
            #1 i_TX_Done = 1'b0;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++; $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      @(posedge CLK);
      #1 i_Reset = 1'b1;
      lat_chk = -1;
      @(posedge CLK);
      #1 i_Reset = 1'b0;
   endtask

   task automatic frame(input logic [8:0] samp, input logic [8:0] oth, input int nrows,
                        input int ncols, input bit rep, input logic [7:0] code, input bit lat);
      i_VSync = 1'b0; i_HSync = 1'b0;
      cycles(2);
      i_VSync = 1'b1;
      for (int r = 0; r < nrows; r++) begin
         for (int c = 0; c < ncols; c++) begin
            i_HSync = 1'b1;
            {i_Red, i_Green, i_Blue} = (r == SR && c == SC) ? samp : oth;
            cycles(1);
         end
         i_HSync = 1'b0;
         {i_Red, i_Green, i_Blue} = 9'o000;
         cycles(2);
      end
      if (rep) exp_q.push_back(code);
      if (lat) lat_chk = cyc;
      i_VSync = 1'b0;
      cycles(4);
   endtask

   initial begin
      int d0;
      // Reset values and single red report with latency
      do_reset();
      chk("rst_dv", {7'd0, o_TX_DV}, 8'h00);
      chk("rst_byte", o_TX_Byte, 8'h00);
      chk("rst_valid", {7'd0, o_Sample_Valid}, 8'h00);
      frame(9'o700, 9'o700, NROW, NCOL, 1'b1, 8'h31, 1'b1);
      cycles(20);
      chk("red_valid", {7'd0, o_Sample_Valid}, 8'h01);
      chk("red_q_empty", 8'(exp_q.size()), 8'h00);

      // Three identical red frames yield one byte
      do_reset();
      d0 = dv_count;
      frame(9'o700, 9'o700, NROW, NCOL, 1'b1, 8'h31, 1'b1);
      frame(9'o700, 9'o700, NROW, NCOL, 1'b0, 8'h00, 1'b0);
      frame(9'o700, 9'o700, NROW, NCOL, 1'b0, 8'h00, 1'b0);
      cycles(20);
      chk("same_count", 8'(dv_count - d0), 8'h01);

      // Red then green
      do_reset();
      frame(9'o700, 9'o700, NROW, NCOL, 1'b1, 8'h31, 1'b1);
      cycles(15);
      frame(9'o070, 9'o070, NROW, NCOL, 1'b1, 8'h32, 1'b1);
      cycles(20);
      chk("rg_q_empty", 8'(exp_q.size()), 8'h00);
      chk("rg_byte_hold", o_TX_Byte, 8'h32);

      // Mixed sample pixel, then black, then undersized frames (no hit)
      frame(9'o305, 9'o000, NROW, NCOL, 1'b1, 8'h3F, 1'b1);
      cycles(15);
      frame(9'o000, 9'o000, NROW, NCOL, 1'b1, 8'h30, 1'b1);
      cycles(15);
      d0 = dv_count;
      frame(9'o700, 9'o700, SR, NCOL, 1'b0, 8'h00, 1'b0);
      frame(9'o700, 9'o700, NROW, SC, 1'b0, 8'h00, 1'b0);
      cycles(20);
      chk("short_count", 8'(dv_count - d0), 8'h00);
      chk("mix_q_empty", 8'(exp_q.size()), 8'h00);

      // Back-pressure: latest code wins
      do_reset();
      i_TX_Active = 1'b1;
      d0 = dv_count;
      frame(9'o070, 9'o070, NROW, NCOL, 1'b0, 8'h00, 1'b0);
      frame(9'o007, 9'o007, NROW, NCOL, 1'b0, 8'h00, 1'b0);
      cycles(10);
      chk("active_count", 8'(dv_count - d0), 8'h00);
      exp_q.push_back(8'h33);
      i_TX_Active = 1'b0;
      cycles(20);
      chk("bp_count", 8'(dv_count - d0), 8'h01);
      chk("bp_q_empty", 8'(exp_q.size()), 8'h00);

      // Async reset mid-WAIT
      do_reset();
      frame(9'o700, 9'o700, NROW, NCOL, 1'b1, 8'h31, 1'b1);
      @(posedge CLK);
      #3 i_Reset = 1'b1;
      #1;
      chk("wait_rst_dv", {7'd0, o_TX_DV}, 8'h00);
      chk("wait_rst_byte", o_TX_Byte, 8'h00);
      chk("wait_rst_valid", {7'd0, o_Sample_Valid}, 8'h00);
      cycles(1);
      i_Reset = 1'b0;
      cycles(15);

      // Async reset mid-frame, after the sample pixel was captured
      i_VSync = 1'b1;
      for (int r = 0; r <= SR; r++) begin
         for (int c = 0; c < NCOL; c++) begin
            i_HSync = 1'b1;
            {i_Red, i_Green, i_Blue} = 9'o700;
            cycles(1);
         end
         i_HSync = 1'b0;
         cycles(2);
      end
      chk("mid_valid_pre", {7'd0, o_Sample_Valid}, 8'h01);
      #3 i_Reset = 1'b1;
      #1;
      chk("mid_rst_valid", {7'd0, o_Sample_Valid}, 8'h00);
      chk("mid_rst_byte", o_TX_Byte, 8'h00);
      i_VSync = 1'b0; i_HSync = 1'b0;
      cycles(1);
      i_Reset = 1'b0;
      frame(9'o700, 9'o700, NROW, NCOL, 1'b1, 8'h31, 1'b1);
      cycles(20);
      chk("post_rst_q_empty", 8'(exp_q.size()), 8'h00);
      chk("post_rst_byte", o_TX_Byte, 8'h31);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
